// File: rtl/mac_feeder.sv
`default_nettype none
// ============================================================================
// mac_feeder : key/query instruction source for a mac_col chain
// Rev 1.0    : initial release
// ============================================================================
module mac_feeder #(
  parameter int bw         = 8,
  parameter int pr         = 8,
  parameter int col        = 8,
  parameter int load_cyc   = col + 2,
  parameter int drain_cyc  = col + 2,
  parameter int addr_w     = 7,
  parameter int key_base   = 0,
  parameter int query_base = 16,
  parameter int nq_w       = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [nq_w-1:0]      num_q,
  input  logic                 ofifo_full,
  output logic                 mem_cen,
  output logic [addr_w-1:0]    mem_addr,
  input  logic [pr*bw-1:0]     mem_rdata,
  output logic [pr*bw-1:0]     q_out,
  output logic [1:0]           o_inst,
  output logic                 busy,
  output logic                 done
);

  localparam int lc_w = $clog2(load_cyc + 1);
  localparam int dc_w = $clog2(drain_cyc + 1);

  localparam logic [lc_w-1:0]   load_last  = lc_w'(load_cyc - 1);
  localparam logic [dc_w-1:0]   drain_last = dc_w'(drain_cyc - 1);
  localparam logic [addr_w-1:0] key_addr   = addr_w'(key_base);
  localparam logic [addr_w-1:0] query_addr = addr_w'(query_base);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [lc_w-1:0]     load_cnt, load_nxt;
  logic [nq_w-1:0]     q_cnt, q_nxt;
  logic [dc_w-1:0]     drain_cnt, drain_nxt;
  logic [nq_w-1:0]     nq_lat, nq_nxt;
  logic [1:0]          inst_nxt;
  logic                cen_nxt;
  logic [addr_w-1:0]   addr_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  // Next-state logic computes the outputs of the upcoming cycle; all outputs are registered.
  // q_cnt counts queries already issued, so EXEC leaves once it equals the latched count.
  always_comb begin
    state_nxt = state;
    load_nxt  = load_cnt;
    q_nxt     = q_cnt;
    drain_nxt = drain_cnt;
    nq_nxt    = nq_lat;
    inst_nxt  = 2'b00;
    cen_nxt   = 1'b1;
    addr_nxt  = mem_addr;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          nq_nxt    = num_q;
          load_nxt  = '0;
          inst_nxt  = 2'b01;
          cen_nxt   = 1'b0;
          addr_nxt  = key_addr;
          busy_nxt  = 1'b1;
        end
      end
      LOAD: begin
        if (load_cnt == load_last) begin
          state_nxt = GAP;
        end else begin
          load_nxt = load_cnt + 1'b1;
          inst_nxt = 2'b01;
          cen_nxt  = 1'b0;
          addr_nxt = key_addr + addr_w'(load_cnt + 1'b1);
        end
      end
      GAP: begin
        if (nq_lat != '0) begin
          state_nxt = EXEC;
          q_nxt     = '0;
          if (!ofifo_full) begin
            inst_nxt = 2'b10;
            cen_nxt  = 1'b0;
            addr_nxt = query_addr;
            q_nxt    = nq_w'(1);
          end
        end else begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end
      end
      EXEC: begin
        if (q_cnt == nq_lat) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end else if (!ofifo_full) begin
          inst_nxt = 2'b10;
          cen_nxt  = 1'b0;
          addr_nxt = query_addr + addr_w'(q_cnt);
          q_nxt    = q_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == drain_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          drain_nxt = drain_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      load_cnt  <= '0;
      q_cnt     <= '0;
      drain_cnt <= '0;
      nq_lat    <= '0;
      o_inst    <= 2'b00;
      mem_cen   <= 1'b1;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_cnt  <= load_nxt;
      q_cnt     <= q_nxt;
      drain_cnt <= drain_nxt;
      nq_lat    <= nq_nxt;
      o_inst    <= inst_nxt;
      mem_cen   <= cen_nxt;
      mem_addr  <= addr_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Read data arrives the cycle after the address, exactly when column 0 samples q_in.
  assign q_out = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mac_feeder.sv
`default_nettype none
// tb_mac_feeder: builds the expected per-cycle trace of each job from the
// phase rules, then compares the DUT against it every cycle.
module tb_mac_feeder;
  localparam int AW         = 7;
  localparam int NQW        = 6;
  localparam int LOAD_CYC   = 10;
  localparam int DRAIN_CYC  = 10;
  localparam int KEY_BASE   = 0;
  localparam int QUERY_BASE = 16;
  localparam int MAXT       = 128;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [NQW-1:0] num_q = '0;
  logic           ofifo_full = 1'b0;
  logic           mem_cen;
  logic [AW-1:0]  mem_addr;
  logic [63:0]    mem_rdata = '0;
  logic [63:0]    q_out;
  logic [1:0]     o_inst;
  logic           busy;
  logic           done;

  mac_feeder dut (
    .clk(clk), .reset(reset), .start(start), .num_q(num_q),
    .ofifo_full(ofifo_full), .mem_cen(mem_cen), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .q_out(q_out), .o_inst(o_inst),
    .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  logic [63:0] mem [0:127];
  always @(posedge clk) if (!mem_cen) mem_rdata <= mem[mem_addr];

  logic [1:0]    e_inst [MAXT];
  logic          e_cen  [MAXT];
  logic [AW-1:0] e_addr [MAXT];
  bit            e_achk [MAXT];
  logic          e_busy [MAXT];
  logic          e_done [MAXT];
  logic [63:0]   e_q    [MAXT];
  bit            e_qchk [MAXT];
  bit            full_pat [MAXT];

  int len, cur_t, errors, checks, done_cnt, done_t;
  bit checking;
  logic [63:0] q_cap12, q_cap15;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, cur_t, act, exp);
    end
  endtask

  task automatic put(int t, logic [1:0] i, logic c, logic [AW-1:0] a, bit ac, logic b, logic d);
    e_inst[t] = i; e_cen[t] = c; e_addr[t] = a; e_achk[t] = ac;
    e_busy[t] = b; e_done[t] = d;
  endtask

  // Expected trace indexed from the first LOAD cycle; full at cycle t governs cycle t+1.
  task automatic build(int nq, int rst_at);
    int t;
    int j;
    logic [AW-1:0] last;
    t = 0; j = 0; last = '0;
    for (int k = 0; k < LOAD_CYC; k++) begin
      last = AW'(KEY_BASE + k);
      put(t, 2'b01, 1'b0, last, 1, 1'b1, 1'b0); t++;
    end
    put(t, 2'b00, 1'b1, last, 0, 1'b1, 1'b0); t++;
    while (j < nq && t < MAXT - 20) begin
      if (!full_pat[t-1]) begin
        last = AW'(QUERY_BASE + j);
        put(t, 2'b10, 1'b0, last, 1, 1'b1, 1'b0); j++;
      end else begin
        put(t, 2'b00, 1'b1, last, j > 0, 1'b1, 1'b0);
      end
      t++;
    end
    for (int k = 0; k < DRAIN_CYC; k++) begin
      put(t, 2'b00, 1'b1, last, 0, 1'b1, 1'b0); t++;
    end
    put(t, 2'b00, 1'b1, last, 0, 1'b0, 1'b1); t++;
    for (int k = 0; k < 2; k++) begin
      put(t, 2'b00, 1'b1, last, 0, 1'b0, 1'b0); t++;
    end
    len = t;
    if (rst_at >= 0) begin
      for (int u = rst_at + 1; u < rst_at + 4; u++) put(u, 2'b00, 1'b1, '0, 1, 1'b0, 1'b0);
      len = rst_at + 4;
    end
    for (int u = 0; u < len; u++) begin
      e_qchk[u] = (u > 0) && (e_cen[u-1] == 1'b0);
      e_q[u]    = (u > 0) ? mem[e_addr[u-1]] : 64'd0;
    end
  endtask

  task automatic run_job(int nq, int fs, int fe, int rst_at, int ign_at);
    for (int t = 0; t < MAXT; t++) full_pat[t] = (t >= fs) && (t <= fe);
    build(nq, rst_at);
    done_cnt = 0; done_t = -1;
    @(posedge clk); #1;
    start = 1'b1; num_q = NQW'(nq); ofifo_full = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < len; t++) begin
      cur_t = t;
      ofifo_full = full_pat[t];
      reset = (t == rst_at);
      start = (t == ign_at);
      if (t == ign_at) num_q = NQW'(9);
      checking = 1'b1;
      @(posedge clk); #1;
    end
    checking = 1'b0; reset = 1'b0; start = 1'b0; ofifo_full = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("o_inst", 64'(o_inst), 64'(e_inst[cur_t]));
        chk("mem_cen", 64'(mem_cen), 64'(e_cen[cur_t]));
        if (e_achk[cur_t]) chk("mem_addr", 64'(mem_addr), 64'(e_addr[cur_t]));
        chk("busy", 64'(busy), 64'(e_busy[cur_t]));
        chk("done", 64'(done), 64'(e_done[cur_t]));
        if (e_qchk[cur_t]) chk("q_out", q_out, e_q[cur_t]);
        if (done === 1'b1) begin done_cnt++; done_t = cur_t; end
        if (cur_t == 12) q_cap12 = q_out;
        if (cur_t == 15) q_cap15 = q_out;
      end
    end
  end

  initial begin
    errors = 0; checks = 0; checking = 1'b0; cur_t = 0;
    for (int i = 0; i < 128; i++) mem[i] = {8{8'(i * 3 + 1)}};
    for (int j = 0; j < 16; j++) mem[16 + j] = {8{8'(8'hA0 + j)}};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_o_inst", 64'(o_inst), 64'd0);
    chk("rst_mem_cen", 64'(mem_cen), 64'd1);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    run_job(4, -1, -1, -1, -1);
    chk("nostall_done_t", 64'(done_t), 64'd25);
    chk("nostall_done_cnt", 64'(done_cnt), 64'd1);
    chk("q_first", q_cap12, 64'hA0A0A0A0A0A0A0A0);
    chk("q_last", q_cap15, 64'hA3A3A3A3A3A3A3A3);

    run_job(4, 12, 14, -1, 5);
    chk("stall_done_t", 64'(done_t), 64'd28);
    chk("stall_done_cnt", 64'(done_cnt), 64'd1);

    run_job(2, 0, 9, -1, -1);
    chk("loadfull_done_t", 64'(done_t), 64'd23);

    run_job(0, -1, -1, -1, -1);
    chk("nq0_done_t", 64'(done_t), 64'd21);

    run_job(4, -1, -1, 12, -1);
    chk("abort_done_cnt", 64'(done_cnt), 64'd0);

    run_job(1, -1, -1, -1, -1);
    chk("restart_done_t", 64'(done_t), 64'd22);
    chk("restart_done_cnt", 64'(done_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Instruction/data source for a chain of mac_col columns; the transmitter side of the column load/execute protocol.
- Reads key vectors, then query vectors, from a synchronous single-port SRAM and drives the first column's `i_inst`/`q_in`.
- Inserts bubbles when the downstream psum output FIFO is full.
- Sits between the activation SRAM and the column array inside the core.

Parameters:
- bw, 8, bits per element
- pr, 8, elements per vector (data width pr*bw)
- col, 8, number of columns in the chain
- load_cyc, 10, consecutive load cycles in the LOAD phase (col+2)
- drain_cyc, 10, idle cycles after the last execute before done (col+2)
- addr_w, 7, SRAM address width
- key_base, 0, SRAM address of first key vector
- query_base, 16, SRAM address of first query vector
- nq_w, 6, width of query count

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begin a job
- num_q  in  nq_w  number of query vectors, sampled on accepted start
- ofifo_full  in  1  downstream psum FIFO full
- mem_cen  out  1  SRAM chip enable, active low
- mem_addr  out  addr_w  SRAM read address
- mem_rdata  in  pr*bw  SRAM read data, valid one cycle after a read
- q_out  out  pr*bw  vector to column 0 `q_in`
- o_inst  out  2  to column 0 `i_inst`; [1] execute, [0] load
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

Behaviour:
- One clock `clk`; reset is synchronous and active-high on `reset`.
- Reset values:
  - state IDLE
  - o_inst=00, mem_cen=1, mem_addr=0, busy=0, done=0
  - all counters 0
- Reset mid-job aborts immediately to these values; no done pulse.
- States:
  - IDLE
    - o_inst=00, mem_cen=1.
    - On start: latch num_q, go to LOAD, busy=1 from the next cycle.
    - start while busy is ignored.
  - LOAD
    - Each cycle k=0..load_cyc-1: o_inst=01, mem_cen=0, mem_addr=key_base+k.
    - ofifo_full is ignored in this state.
    - After load_cyc cycles go to GAP.
  - GAP
    - One cycle with o_inst=00, mem_cen=1.
    - Then EXEC if latched num_q>0, else DRAIN.
  - EXEC
    - Per query index j=0..num_q-1: when ofifo_full=0, issue o_inst=10, mem_cen=0, mem_addr=query_base+j, then j++.
    - When ofifo_full=1: bubble with o_inst=00, mem_cen=1; j and mem_addr hold.
    - After the issue of j=num_q-1 go to DRAIN.
  - DRAIN
    - o_inst=00, mem_cen=1 for drain_cyc cycles.
    - Then done=1 for exactly one cycle, busy=0 in that same cycle, and return to IDLE.
- Timing:
  - o_inst, mem_cen and mem_addr are registered and change together.
  - q_out = mem_rdata, a combinational passthrough. It therefore carries the vector addressed in cycle t during cycle t+1, which is the cycle mac_col samples `q_in` for the instruction it received in cycle t.
  - q_out is undefined and unused when no read was issued in the prior cycle.
- ofifo_full:
  - Sampled combinationally by the next-state logic; it affects the registered outputs of the next cycle.
  - A full→not-full transition resumes issue on the next cycle with no lost or duplicated index.
- Counters:
  - Load counter width clog2(load_cyc+1).
  - Query index is nq_w bits and never wraps, since it stops at num_q-1.
  - Drain counter width clog2(drain_cyc+1).
  - Addresses are base+index modulo 2^addr_w; overlapping regions are the caller's responsibility.
- Total job length without stalls: load_cyc + 1 + num_q + drain_cyc cycles from first LOAD cycle to done.

Test Plan:
- Reset, then start with num_q=4 and no stalls:
  - 10 cycles o_inst=01 with addr 0..9, then 1 cycle 00.
  - 4 cycles o_inst=10 with addr 16..19, then 10 cycles 00.
  - done pulses once, 25 cycles after the first LOAD cycle.
- q_out alignment: preload mem[16+j]=j+0xA0 in every byte. q_out in the cycle after each execute issue equals 0xA0A0…, 0xA1A1…, 0xA2A2…, 0xA3A3….
- Stall: num_q=4, ofifo_full=1 for 3 cycles after the 2nd execute:
  - 3 cycles o_inst=00 with mem_addr held at 17.
  - Then addr 18,19 issue; done arrives 3 cycles later than the no-stall case.
- ofifo_full=1 throughout LOAD: all 10 loads issue back-to-back, unaffected.
- num_q=0: LOAD(10), GAP(1), DRAIN(10), then done; no execute ever issued.
- Reset asserted in EXEC after 2 queries: next cycle shows o_inst=00, busy=0, no done. A fresh start with num_q=1 then runs the full sequence correctly.
